g1_tx: RTL

Serial frame transmitter that drives the single-bit line `a` sampled by the g1 pattern receiver. It sits at the sending end of that link. On a start request it latches a parallel word and shifts out one frame, one bit per `clk`:

- a preamble run of ones,
- a zero separator,
- the data bits, MSB first,
- an even-parity bit.

The line is held low between frames.

---
 rtl/g1_tx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/g1_tx.sv
// g1_tx: serial frame transmitter for the g1 pattern receiver.
// Frame = PRE_LEN ones, one zero, DATA_W data bits MSB first, even parity; line low between frames.
module g1_tx #(
   parameter int PRE_LEN = 5,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   output logic              a,
   output logic              busy,
   output logic              done
);

   localparam int CW_PRE = $clog2(PRE_LEN + 1);
   localparam int CW_DAT = $clog2(DATA_W + 1);
   localparam int CW     = (CW_PRE > CW_DAT) ? CW_PRE : CW_DAT;

   typedef enum logic [2:0] {IDLE, PRE, SEP, DATA, PAR, DONE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic              par, par_nx;
   logic              a_nx, busy_nx, done_nx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         par   <= 1'b0;
         a     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         shreg <= shreg_nx;
         par   <= par_nx;
         a     <= a_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   // Outputs are registered, so each branch computes the line value for the
   // state being entered; the shift happens on the edge that presents its MSB.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      par_nx   = par;
      a_nx     = 1'b0;
      busy_nx  = busy;
      done_nx  = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
            if (start) begin
               state_nx = PRE;
               shreg_nx = din;
               par_nx   = 1'b0;
               cnt_nx   = CW'(PRE_LEN);
               a_nx     = 1'b1;
               busy_nx  = 1'b1;
            end
         end

         PRE: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nx = SEP;
               a_nx     = 1'b0;
            end else begin
               a_nx = 1'b1;
            end
         end

         SEP: begin
            state_nx = DATA;
            cnt_nx   = CW'(DATA_W);
            a_nx     = shreg[DATA_W-1];
            shreg_nx = shreg << 1;
            par_nx   = par ^ shreg[DATA_W-1];
         end

         DATA: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nx = PAR;
               a_nx     = par;
            end else begin
               a_nx     = shreg[DATA_W-1];
               shreg_nx = shreg << 1;
               par_nx   = par ^ shreg[DATA_W-1];
            end
         end

         PAR: begin
            state_nx = DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
         end

         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

endmodule
